// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory between the core (port 0)
// and the debug/loader path (port 1); each access runs IDLE -> ACCESS -> RESP.
module dmem_arbiter #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0,
   input  logic        we0,
   input  logic [31:0] addr0,
   input  logic [31:0] wdata0,
   input  logic        req1,
   input  logic        we1,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] rdata,
   output logic        err,
   output logic        busy,
   output logic        WE,
   output logic [31:0] WA,
   output logic [31:0] WD,
   input  logic [31:0] DataRD
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [31:0] LIMIT = 32'(DEPTH);

   state_t      state, state_nxt;
   logic        last, owner, we_l, bad;
   logic        gnt, sel_we, in_range;
   logic [31:0] sel_addr, sel_wdata;

   // On a tie the port that did not win last time is served.
   always_comb begin
      gnt       = req1 & (~req0 | ~last);
      sel_we    = gnt ? we1    : we0;
      sel_addr  = gnt ? addr1  : addr0;
      sel_wdata = gnt ? wdata1 : wdata0;
      in_range  = (sel_addr < LIMIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req0 || req1) state_nxt = ACCESS;
         ACCESS:  state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last  <= 1'b1;
         owner <= 1'b0;
         we_l  <= 1'b0;
         bad   <= 1'b0;
         WE    <= 1'b0;
         WA    <= '0;
         WD    <= '0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         rdata <= '0;
         err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  owner <= gnt;
                  last  <= gnt;
                  we_l  <= sel_we;
                  // Out-of-range accesses never drive the memory.
                  if (in_range) begin
                     WE  <= sel_we;
                     WA  <= sel_addr;
                     WD  <= sel_wdata;
                     bad <= 1'b0;
                  end else begin
                     WE  <= 1'b0;
                     WA  <= '0;
                     WD  <= '0;
                     bad <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               WE    <= 1'b0;
               rdata <= (!we_l && !bad) ? DataRD : 32'h0;
               err   <= bad;
               done0 <= ~owner;
               done1 <= owner;
            end
            RESP: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               err   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random two-port traffic, checked
// against a word-array memory model and a round-robin fairness rule.
module tb_dmem_arbiter;

   localparam int DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic        done0, done1, err, busy, WE;
   logic [31:0] rdata, WA, WD, DataRD;

   always #5 clk = ~clk;

   dmem_arbiter #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .done0(done0), .done1(done1), .rdata(rdata), .err(err), .busy(busy),
      .WE(WE), .WA(WA), .WD(WD), .DataRD(DataRD)
   );

   // Memory behind the arbiter, with a side port for preloading.
   logic [31:0] mem [0:DEPTH-1];
   logic        pre_we = 1'b0;
   logic [9:0]  pre_a  = '0;
   logic [31:0] pre_d  = '0;

   always @(posedge clk) begin
      if (WE && WA < DEPTH) mem[WA[9:0]] <= WD;
      else if (pre_we)      mem[pre_a]   <= pre_d;
   end
   assign DataRD = (WA < DEPTH) ? mem[WA[9:0]] : 32'h0;

   int          vectors = 0, miscompares = 0;
   logic [31:0] ref_mem [0:DEPTH-1];
   logic        pend [2];
   logic        pwe  [2];
   logic [31:0] paddr[2];
   logic [31:0] pwd  [2];
   logic [1:0]  hist [3];
   logic        got  [2];
   int          last_served;
   int          served_q[$];
   logic        we_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
      pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwd[p] = d;
   endtask

   // One clock: drive requests after the edge, observe at the falling edge, score any done.
   task automatic step();
      int          s, esv;
      logic        ee;
      logic [31:0] er;
      @(posedge clk); #1;
      req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pwd[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pwd[1];
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = {req1, req0};
      @(negedge clk);
      got[0] = done0; got[1] = done1;
      if (WE) we_seen = 1'b1;
      chk("done_overlap", 32'(done0 & done1), 32'h0);
      if (done0 || done1) begin
         s = done1 ? 1 : 0;
         // Requests seen at the grant edge, two edges before done.
         case (hist[2])
            2'b11:   esv = (last_served == 0) ? 1 : 0;
            2'b10:   esv = 1;
            2'b01:   esv = 0;
            default: esv = 2;
         endcase
         chk("grant", 32'(s), 32'(esv));
         last_served = s;
         served_q.push_back(s);
         ee = (paddr[s] >= DEPTH);
         er = 32'h0;
         if (!ee) begin
            if (pwe[s]) ref_mem[paddr[s][9:0]] = pwd[s];
            else        er = ref_mem[paddr[s][9:0]];
         end
         chk("rdata", rdata, er);
         chk("err", 32'(err), 32'(ee));
         pend[s] = 1'b0;
         if (s == 0) req0 = 1'b0; else req1 = 1'b0;
      end
   endtask

   task automatic wait_done(input int p, input int budget, output int n);
      n = 0;
      do begin step(); n++; end while (!got[p] && n < budget);
      chk("done_timeout", 32'(got[p]), 32'h1);
   endtask

   initial begin
      int n, cnt, cyc, r;
      logic [31:0] a, v;
      rst_n = 1'b1;
      req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
      req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
      for (int i = 0; i < 3; i++) hist[i] = 2'b00;
      for (int p = 0; p < 2; p++) begin
         pend[p] = 0; pwe[p] = 0; paddr[p] = 0; pwd[p] = 0; got[p] = 0;
      end
      last_served = 1;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_WE", 32'(WE), 32'h0);
      chk("rst_WA", WA, 32'h0);
      chk("rst_WD", WD, 32'h0);
      chk("rst_done", 32'({done1, done0}), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         pre_we = 1'b1;
         pre_a  = (i == 16) ? 10'd1023 : 10'(i);
         pre_d  = (i < 3) ? 32'(i + 1) : ((i == 16) ? 32'h0 : 32'h100 + 32'(i));
         ref_mem[pre_a] = pre_d;
      end
      @(negedge clk);
      pre_we = 1'b0;
      rst_n  = 1'b1;

      // Port 0 read of preloaded word.
      we_seen = 0;
      issue(0, 1'b0, 32'd2, 32'h0);
      wait_done(0, 10, n);
      chk("t1_latency", 32'(n), 32'd3);
      chk("t1_rdata", rdata, 32'd3);
      chk("t1_we_never", 32'(we_seen), 32'h0);

      // Port 1 write then read back.
      issue(1, 1'b1, 32'd5, 32'hDEADBEEF);
      wait_done(1, 10, n);
      chk("t2_wr_rdata", rdata, 32'h0);
      chk("t2_mem5", mem[5], 32'hDEADBEEF);
      issue(1, 1'b0, 32'd5, 32'h0);
      wait_done(1, 10, n);
      chk("t2_rd_rdata", rdata, 32'hDEADBEEF);

      // Both ports contending: grants alternate.
      served_q.delete();
      issue(0, 1'b0, 32'd0, 32'h0);
      issue(1, 1'b0, 32'd1, 32'h0);
      cnt = 0; cyc = 0;
      while (cnt < 4 && cyc < 60) begin
         step(); cyc++;
         for (int p = 0; p < 2; p++)
            if (got[p]) begin
               cnt++;
               if (cnt < 4) issue(p, 1'b0, 32'(p), 32'h0);
            end
      end
      while ((pend[0] || pend[1]) && cyc < 60) begin step(); cyc++; end
      chk("t3_count", 32'(served_q.size() >= 4), 32'h1);
      if (served_q.size() >= 4)
         for (int i = 0; i < 4; i++) chk("t3_order", 32'(served_q[i]), 32'(i % 2));

      // Out-of-range write, then the last legal word.
      we_seen = 0;
      issue(0, 1'b1, 32'd1024, 32'd7);
      wait_done(0, 10, n);
      chk("t4_we_never", 32'(we_seen), 32'h0);
      chk("t4_err", 32'(err), 32'h1);
      chk("t4_rdata", rdata, 32'h0);
      issue(0, 1'b1, 32'd1023, 32'd7);
      wait_done(0, 10, n);
      chk("t4b_err", 32'(err), 32'h0);
      chk("t4b_mem", mem[1023], 32'd7);

      // Reset while a write sits in ACCESS.
      issue(0, 1'b1, 32'd0, 32'd9);
      step(); step();
      chk("t5_we_access", 32'(WE), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t5_we_drop", 32'(WE), 32'h0);
      chk("t5_busy", 32'(busy), 32'h0);
      pend[0] = 0; req0 = 0;
      for (int i = 0; i < 3; i++) hist[i] = 2'b00;
      last_served = 1;
      repeat (2) @(negedge clk);
      chk("t5_done", 32'({done1, done0}), 32'h0);
      chk("t5_mem0", mem[0], 32'd1);
      rst_n = 1'b1;

      // Lone port 1 request right after reset (last=1).
      issue(1, 1'b0, 32'd2, 32'h0);
      wait_done(1, 10, n);
      chk("t6_latency", 32'(n), 32'd3);

      // Random traffic.
      cnt = 0; cyc = 0;
      while (cnt < 40 && cyc < 2000) begin
         for (int p = 0; p < 2; p++)
            if (!pend[p] && $urandom_range(0, 1) == 1) begin
               r = $urandom_range(0, 9);
               if (r < 7)       a = 32'($urandom_range(0, 15));
               else if (r == 7) a = 32'd1023;
               else if (r == 8) a = 32'd1024;
               else             a = $urandom | 32'h400;
               v = $urandom;
               issue(p, 1'($urandom_range(0, 1)), a, v);
            end
         step(); cyc++;
         cnt += int'(got[0]) + int'(got[1]);
      end
      while ((pend[0] || pend[1]) && cyc < 2100) begin step(); cyc++; end
      chk("rand_drained", 32'({pend[1], pend[0]}), 32'h0);
      for (int i = 0; i < 16; i++) chk("rand_mem", mem[i], ref_mem[i]);
      chk("rand_mem1023", mem[1023], ref_mem[1023]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
